// File: rtl/clock_pkg.sv
// Shared mode encodings, field limits and wrap helpers for the
// time-of-day clock with button-driven set mode.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;

    function automatic logic [4:0] inc_hour(input logic [4:0] h);
        return (h == MAX_HOUR) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [5:0] inc_60(
        input logic [5:0] v,
        input logic [5:0] max
    );
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/one_sec_prescaler.sv
// Divides the system clock down to a one-cycle strobe per second and
// reports whether the count is in the first half of the second.
module one_sec_prescaler #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic CLOCK_50MHz,
    input  logic nRESET,
    input  logic clear,
    output logic sec_pulse,
    output logic half_sec_low
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        pulse_d = 1'b0;
        if (clear || cnt_q == TERM) begin
            cnt_d = '0;
        end
        // a clear restarts the second, so it never counts as a wrap
        if (cnt_q == TERM && !clear) begin
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50MHz or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign sec_pulse    = pulse_q;
    assign half_sec_low = (cnt_q < HALF);

endmodule

// File: rtl/clock_set_controller.sv
// Time-of-day keeper with a RUN / SET_HOUR / SET_MIN mode FSM driven
// by short and long button presses, plus an idle timeout back to RUN.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       CLOCK_50MHz,
    input  logic       nRESET,
    input  logic       B_Short,
    input  logic       B_Long,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_pulse
);

    localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

    mode_e         mode_q, mode_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic [TW-1:0] to_q, to_d;
    logic          blink_q, blink_d;
    logic          tick;
    logic          half_low;
    logic          to_run;
    logic          clear;

    one_sec_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_presc (
        .CLOCK_50MHz  (CLOCK_50MHz),
        .nRESET       (nRESET),
        .clear        (clear),
        .sec_pulse    (tick),
        .half_sec_low (half_low)
    );

    always_comb begin
        mode_d    = mode_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        to_d      = to_q;
        to_run    = 1'b0;

        unique case (mode_q)
            MODE_RUN: begin
                to_d = '0;
                if (tick) begin
                    seconds_d = inc_60(seconds_q, MAX_SEC);
                    if (seconds_q == MAX_SEC) begin
                        minutes_d = inc_60(minutes_q, MAX_MIN);
                        if (minutes_q == MAX_MIN) begin
                            hours_d = inc_hour(hours_q);
                        end
                    end
                end
                if (B_Long) begin
                    mode_d = MODE_SET_HOUR;
                end
            end
            MODE_SET_HOUR: begin
                if (B_Long) begin
                    mode_d = MODE_SET_MIN;
                end else if (B_Short) begin
                    hours_d = inc_hour(hours_q);
                end
            end
            MODE_SET_MIN: begin
                if (B_Long) begin
                    to_run = 1'b1;
                end else if (B_Short) begin
                    minutes_d = inc_60(minutes_q, MAX_MIN);
                end
            end
            default: begin
                to_run = 1'b1;
            end
        endcase

        // idle seconds in a set state; any press restarts the count
        if (mode_q != MODE_RUN) begin
            if (B_Long || B_Short) begin
                to_d = '0;
            end else if (tick) begin
                if (to_q == TO_LAST) begin
                    to_d   = '0;
                    to_run = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
        end

        if (to_run) begin
            mode_d    = MODE_RUN;
            seconds_d = '0;
        end

        clear   = to_run;
        blink_d = (mode_d != MODE_RUN) && half_low;
    end

    always_ff @(posedge CLOCK_50MHz or negedge nRESET) begin
        if (!nRESET) begin
            mode_q    <= MODE_RUN;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            to_q      <= '0;
            blink_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            to_q      <= to_d;
            blink_q   <= blink_d;
        end
    end

    assign hours     = hours_q;
    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign mode      = mode_q;
    assign blink     = blink_q;
    assign sec_pulse = tick;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller at CLK_HZ=10, TIMEOUT_S=3:
// a press-vector table followed by hand-written multi-cycle sequences.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bs = 1'b0;
    logic       bl = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       sec_pulse;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       s;
        logic       l;
        logic [1:0] m;
        logic [4:0] h;
        logic [5:0] mi;
    } vec_t;

    vec_t vecs[8];

    clock_set_controller #(
        .CLK_HZ    (10),
        .TIMEOUT_S (3)
    ) dut (
        .CLOCK_50MHz (clk),
        .nRESET      (rst_n),
        .B_Short     (bs),
        .B_Long      (bl),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .mode        (mode),
        .blink       (blink),
        .sec_pulse   (sec_pulse)
    );

    always #5 clk = ~clk;

    function automatic int pack(
        input logic [1:0] m,
        input logic [4:0] h,
        input logic [5:0] mi,
        input logic [5:0] s
    );
        return int'({13'd0, m, h, mi, s});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press(input logic s, input logic l);
        bs = s;
        bl = l;
        @(negedge clk);
        bs = 1'b0;
        bl = 1'b0;
    endtask

    task automatic press_n(input int n);
        repeat (n) press(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        bs    = 1'b0;
        bl    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int np;
        int bad;
        int found;
        int last;
        int first;
        int highs;
        int changes;
        int zeros;
        logic prev;

        vecs[0] = '{1'b1, 1'b0, 2'd0, 5'd0, 6'd0};
        vecs[1] = '{1'b0, 1'b1, 2'd1, 5'd0, 6'd0};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 5'd1, 6'd0};
        vecs[3] = '{1'b1, 1'b1, 2'd2, 5'd1, 6'd0};
        vecs[4] = '{1'b1, 1'b0, 2'd2, 5'd1, 6'd1};
        vecs[5] = '{1'b1, 1'b0, 2'd2, 5'd1, 6'd2};
        vecs[6] = '{1'b0, 1'b0, 2'd2, 5'd1, 6'd2};
        vecs[7] = '{1'b0, 1'b1, 2'd0, 5'd1, 6'd2};

        @(negedge clk);
        chk("reset_state",
            int'({hours, minutes, seconds, mode, blink, sec_pulse}), 0);
        rst_n = 1'b1;

        // press table, all within the first second after reset
        for (int i = 0; i < 8; i++) begin
            press(vecs[i].s, vecs[i].l);
            chk($sformatf("vec%0d", i),
                pack(mode, hours, minutes, seconds),
                pack(vecs[i].m, vecs[i].h, vecs[i].mi, 6'd0));
        end

        // free run: 1-cycle pulse every 10 cycles, minute carry at 600
        do_reset();
        np = 0; bad = 0; last = 0; first = 0;
        for (int k = 1; k <= 610; k++) begin
            step();
            if (sec_pulse) begin
                np++;
                if (last == 0) first = k;
                else if (k - last != 10) bad++;
                last = k;
            end
            if (k == 600) begin
                chk("t1_600", pack(mode, hours, minutes, seconds),
                    pack(2'd0, 5'd0, 6'd0, 6'd59));
            end
        end
        chk("t1_610", pack(mode, hours, minutes, seconds),
            pack(2'd0, 5'd0, 6'd1, 6'd0));
        chk("t1_first_pulse", first, 10);
        chk("t1_pulse_count", np, 61);
        chk("t1_pulse_spacing", bad, 0);

        // full-day wrap from 23:59:59
        do_reset();
        press(1'b0, 1'b1);
        press_n(23);
        press(1'b0, 1'b1);
        press_n(59);
        chk("t2_set", pack(mode, hours, minutes, seconds),
            pack(2'd2, 5'd23, 6'd59, 6'd0));
        press(1'b0, 1'b1);
        chk("t2_run", pack(mode, hours, minutes, seconds),
            pack(2'd0, 5'd23, 6'd59, 6'd0));
        found = 0;
        for (int k = 0; k < 700; k++) begin
            step();
            if (sec_pulse && seconds == 6'd59) begin
                found = 1;
                break;
            end
        end
        chk("t2_reach_59", found, 1);
        step();
        chk("t2_wrap", pack(mode, hours, minutes, seconds),
            pack(2'd0, 5'd0, 6'd0, 6'd0));

        // blink, hour/minute edit, return to RUN
        do_reset();
        chk("t3_blink_run", int'(blink), 0);
        press(1'b0, 1'b1);
        chk("t3_mode1", int'(mode), 1);
        prev = blink; highs = 0; changes = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (blink) highs++;
            if (k > 0 && blink != prev) changes++;
            prev = blink;
        end
        chk("t3_blink_highs", highs, 10);
        chk("t3_blink_toggles", int'(changes >= 3), 1);
        press_n(5);
        chk("t3_hours5", pack(mode, hours, minutes, seconds),
            pack(2'd1, 5'd5, 6'd0, 6'd0));
        press(1'b0, 1'b1);
        press_n(61);
        chk("t3_min_wrap", pack(mode, hours, minutes, seconds),
            pack(2'd2, 5'd5, 6'd1, 6'd0));
        press(1'b0, 1'b1);
        chk("t3_back_run", pack(mode, hours, minutes, seconds),
            pack(2'd0, 5'd5, 6'd1, 6'd0));
        chk("t3_blink_off", int'(blink), 0);
        zeros = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k <= 10 && seconds == 6'd0) zeros++;
        end
        chk("t3_hold_zero", zeros, 10);
        chk("t3_first_inc", int'(seconds), 1);

        // timeout after three idle seconds
        do_reset();
        press(1'b0, 1'b1);
        np = 0; bad = 0; found = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (mode != 2'd1) bad++;
            if (sec_pulse) begin
                np++;
                if (np == 3) begin
                    step();
                    found = 1;
                    break;
                end
            end
        end
        chk("t4_timeout_seen", found, 1);
        chk("t4_mode_held", bad, 0);
        chk("t4_timeout", pack(mode, hours, minutes, seconds),
            pack(2'd0, 5'd0, 6'd0, 6'd0));

        // a press on the second idle pulse restarts the count
        press(1'b0, 1'b1);
        np = 0; bad = 0; found = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (mode != 2'd1) bad++;
            if (sec_pulse) begin
                np++;
                if (np == 2) begin
                    press(1'b1, 1'b0);
                end else if (np == 5) begin
                    step();
                    found = 1;
                    break;
                end
            end
        end
        chk("t4_restart_seen", found, 1);
        chk("t4_restart_held", bad, 0);
        chk("t4_restart", pack(mode, hours, minutes, seconds),
            pack(2'd0, 5'd1, 6'd0, 6'd0));

        // long press coinciding with a tick in RUN
        do_reset();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (sec_pulse) begin
                found = 1;
                break;
            end
        end
        chk("t5_tick_seen", found, 1);
        press(1'b0, 1'b1);
        chk("t5_tick_then_set", pack(mode, hours, minutes, seconds),
            pack(2'd1, 5'd0, 6'd0, 6'd1));

        // asynchronous reset in the middle of a minute edit
        do_reset();
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press_n(17);
        chk("t6_edit", pack(mode, hours, minutes, seconds),
            pack(2'd2, 5'd0, 6'd17, 6'd0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset",
            int'({hours, minutes, seconds, mode, blink, sec_pulse}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
